spi_byte_slave: RTL and testbench

Mode-0 SPI slave byte engine. It oversamples the external SCLK, MOSI and CS_N pins in the `clk` domain, deserialises MOSI into bytes and serialises response bytes onto MISO. It sits directly upstream of the SPI-to-AXI-Stream adapter: it feeds the adapter received bytes and takes response bytes from it through a one-entry TX holding register.

---
 rtl/spi_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 37 +++
 rtl/spi_byte_slave.sv | 197 +++++++++++++++++++
 tb/tb_spi_byte_slave.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared SPI definitions: byte width, default idle byte and slave state encoding.
package spi_pkg;

  localparam int unsigned SPI_BYTE_W = 8;

  localparam logic [SPI_BYTE_W-1:0] SPI_IDLE_BYTE = 8'h00;

  typedef enum logic [0:0] {
    IDLE,
    ACTIVE
  } spi_slv_state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous pin, with rise/fall detect on the
// synchronised value.
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q, sync_d;
  logic              dly_q, dly_d;

  always_comb begin
    sync_d = {sync_q[Stages-2:0], din_i};
    dly_d  = sync_q[Stages-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {Stages{ResetVal}};
      dly_q  <= ResetVal;
    end else begin
      sync_q <= sync_d;
      dly_q  <= dly_d;
    end
  end

  assign sync_o = sync_q[Stages-1];
  assign rise_o = sync_o & ~dly_q;
  assign fall_o = ~sync_o & dly_q;

endmodule

// File: rtl/spi_byte_slave.sv
// Mode-0 SPI slave byte engine with oversampled pins and a one-entry TX holding register.
// Optional idle-byte substitution counter enabled by SPI_SLAVE_UNDERRUN_CNT_EN.
module spi_byte_slave
  import spi_pkg::*;
#(
  parameter logic [SPI_BYTE_W-1:0] IDLE_BYTE   = SPI_IDLE_BYTE,
  parameter int unsigned           SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  cs_n_pin,
  output logic                  miso,
  output logic                  miso_oe,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic                  busy,
  output logic                  cs_n,
  output logic [7:0]            underrun_cnt
);

  localparam int unsigned CntW = $clog2(SPI_BYTE_W);
  localparam logic [CntW-1:0] LastBit = CntW'(SPI_BYTE_W - 1);

  logic sclk_rise, sclk_fall, unused_sclk_sync;
  logic cs_rise, cs_fall;
  logic mosi_s;

  spi_sync_edge #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b0)
  ) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .din_i  (sclk),
    .sync_o (unused_sclk_sync),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // Chip select resets to the deasserted level so a held-low pin re-enters cleanly.
  spi_sync_edge #(
    .Stages   (SYNC_STAGES),
    .ResetVal (1'b1)
  ) u_cs_sync (
    .clk    (clk),
    .rst    (rst),
    .din_i  (cs_n_pin),
    .sync_o (cs_n),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  // Same depth as the SCLK path so MOSI is sampled in step with the detected edge.
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;

  always_comb begin
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_sync_q <= '0;
    end else begin
      mosi_sync_q <= mosi_sync_d;
    end
  end

  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  spi_slv_state_t        state_q, state_d;
  logic [CntW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [SPI_BYTE_W-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_BYTE_W-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_BYTE_W-1:0] rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic [SPI_BYTE_W-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  reload_en;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    reload_en   = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          state_d    = ACTIVE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          reload_en  = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d    = IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
          tx_shift_d = '0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LastBit) begin
            rx_data_d  = {rx_shift_q[SPI_BYTE_W-2:0], mosi_s};
            rx_valid_d = 1'b1;
          end
        end else if (sclk_fall) begin
          if (bit_cnt_q == '0) begin
            reload_en = 1'b1;
          end else begin
            tx_shift_d = tx_shift_q << 1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A load cannot collide with a consuming reload: tx_ready is low while full.
    if (reload_en) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = IDLE_BYTE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

`ifdef SPI_SLAVE_UNDERRUN_CNT_EN
  logic [7:0] underrun_q, underrun_d;

  always_comb begin
    underrun_d = underrun_q;
    if (reload_en && !hold_full_q && (underrun_q != 8'hFF)) begin
      underrun_d = underrun_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 8'h00;
    end else begin
      underrun_q <= underrun_d;
    end
  end

  assign underrun_cnt = underrun_q;
`else
  assign underrun_cnt = 8'h00;
`endif

  assign busy     = (state_q == ACTIVE);
  assign miso_oe  = busy;
  assign miso     = busy & tx_shift_q[SPI_BYTE_W-1];
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign tx_ready = ~hold_full_q;

endmodule

// File: tb/tb_spi_byte_slave.sv
// Directed self-checking bench for spi_byte_slave: reset, single byte, back-to-back,
// underrun, abort, overflow and reset mid-transfer.
module tb_spi_byte_slave;

  logic       clk = 1'b0;
  logic       rst, sclk, mosi, cs_n_pin;
  logic       miso, miso_oe, rx_valid, tx_valid, tx_ready, busy, cs_n;
  logic [7:0] rx_data, tx_data, underrun_cnt;

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] rx_log[$];
  logic [7:0] got;

  localparam logic [7:0] IdleByte = 8'h00;
`ifdef SPI_SLAVE_UNDERRUN_CNT_EN
  localparam logic [7:0] UnderrunExp = 8'd2;
`else
  localparam logic [7:0] UnderrunExp = 8'd0;
`endif

  spi_byte_slave dut (
    .clk          (clk),
    .rst          (rst),
    .sclk         (sclk),
    .mosi         (mosi),
    .cs_n_pin     (cs_n_pin),
    .miso         (miso),
    .miso_oe      (miso_oe),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .cs_n         (cs_n),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) rx_log.push_back(rx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_miso"}, miso, 1'b0);
    check({pfx, "_miso_oe"}, miso_oe, 1'b0);
    check({pfx, "_rx_data"}, rx_data, 8'h00);
    check({pfx, "_rx_valid"}, rx_valid, 1'b0);
    check({pfx, "_tx_ready"}, tx_ready, 1'b1);
    check({pfx, "_busy"}, busy, 1'b0);
    check({pfx, "_cs_n"}, cs_n, 1'b1);
    check({pfx, "_underrun"}, underrun_cnt, 8'h00);
  endtask

  task automatic push_tx(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    #10;
    tx_valid = 1'b0;
  endtask

  // Shifts nbits MSB first; host samples MISO on each SCLK rising edge.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit do_load,
                      input logic [7:0] ld, input bit last_fall, output logic [7:0] mi);
    mi = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      #80;
      sclk = 1'b1;
      mi[7-i] = miso;
      if (do_load && i == 3) begin
        push_tx(ld);
        #70;
      end else begin
        #80;
      end
      if (last_fall || i != nbits - 1) sclk = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; sclk = 1'b0; mosi = 1'b0; cs_n_pin = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    #40;
    check_reset("por");
    rst = 1'b0;
    #40;

    // Underrun: two bytes, nothing loaded; CS released while SCLK is still high
    cs_n_pin = 1'b0;
    #80;
    check("ur_busy", busy, 1'b1);
    check("ur_miso_oe", miso_oe, 1'b1);
    check("ur_cs_n", cs_n, 1'b0);
    xfer(8'h0F, 8, 1'b0, 8'h00, 1'b1, got);
    check("ur_miso0", got, IdleByte);
    xfer(8'hF0, 8, 1'b0, 8'h00, 1'b0, got);
    check("ur_miso1", got, IdleByte);
    cs_n_pin = 1'b1;
    #80;
    sclk = 1'b0;
    #80;
    check("ur_cnt", underrun_cnt, UnderrunExp);
    check("ur_rx_n", rx_log.size(), 2);
    check("ur_rx0", rx_log[0], 8'h0F);
    check("ur_rx1", rx_log[1], 8'hF0);
    check("ur_idle_busy", busy, 1'b0);
    check("ur_idle_miso", miso, 1'b0);
    check("ur_idle_oe", miso_oe, 1'b0);
    rx_log.delete();

    // Single byte with preloaded response
    push_tx(8'h5C);
    check("sb_rdy_lo", tx_ready, 1'b0);
    #20;
    cs_n_pin = 1'b0;
    #80;
    check("sb_rdy_hi", tx_ready, 1'b1);
    xfer(8'hA2, 8, 1'b0, 8'h00, 1'b1, got);
    check("sb_miso", got, 8'h5C);
    #80;
    cs_n_pin = 1'b1;
    #160;
    check("sb_rx_n", rx_log.size(), 1);
    check("sb_rx0", rx_log[0], 8'hA2);
    rx_log.delete();

    // Back-to-back: response loaded in byte N goes out in byte N+1
    cs_n_pin = 1'b0;
    #80;
    xfer(8'hA1, 8, 1'b1, 8'hC1, 1'b1, got);
    check("bb_miso0", got, IdleByte);
    xfer(8'h00, 8, 1'b1, 8'hC2, 1'b1, got);
    check("bb_miso1", got, 8'hC1);
    xfer(8'h10, 8, 1'b0, 8'h00, 1'b1, got);
    check("bb_miso2", got, 8'hC2);
    #80;
    cs_n_pin = 1'b1;
    #160;
    check("bb_rx_n", rx_log.size(), 3);
    check("bb_rx0", rx_log[0], 8'hA1);
    check("bb_rx1", rx_log[1], 8'h00);
    check("bb_rx2", rx_log[2], 8'h10);
    rx_log.delete();

    // Abort after 5 bits; byte loaded during the partial byte survives
    cs_n_pin = 1'b0;
    #80;
    xfer(8'hFF, 5, 1'b1, 8'h77, 1'b1, got);
    #80;
    cs_n_pin = 1'b1;
    #160;
    check("ab_rx_none", rx_log.size(), 0);
    check("ab_hold_kept", tx_ready, 1'b0);
    cs_n_pin = 1'b0;
    #80;
    check("ab_hold_taken", tx_ready, 1'b1);
    xfer(8'h3C, 8, 1'b0, 8'h00, 1'b1, got);
    check("ab_miso", got, 8'h77);
    #80;
    cs_n_pin = 1'b1;
    #160;
    check("ab_rx_n", rx_log.size(), 1);
    check("ab_rx0", rx_log[0], 8'h3C);
    rx_log.delete();

    // Overflow: second load while full is dropped
    push_tx(8'h11);
    check("ov_rdy_lo", tx_ready, 1'b0);
    push_tx(8'h22);
    #20;
    cs_n_pin = 1'b0;
    #80;
    check("ov_rdy_hi", tx_ready, 1'b1);
    xfer(8'h5A, 8, 1'b0, 8'h00, 1'b1, got);
    check("ov_miso0", got, 8'h11);
    xfer(8'hA5, 8, 1'b0, 8'h00, 1'b1, got);
    check("ov_miso1", got, IdleByte);
    #80;
    cs_n_pin = 1'b1;
    #160;
    check("ov_rx_n", rx_log.size(), 2);
    check("ov_rx0", rx_log[0], 8'h5A);
    check("ov_rx1", rx_log[1], 8'hA5);
    rx_log.delete();

    // Reset mid-transfer, then a clean transaction
    push_tx(8'h99);
    cs_n_pin = 1'b0;
    #80;
    xfer(8'hFF, 3, 1'b0, 8'h00, 1'b1, got);
    rst = 1'b1;
    cs_n_pin = 1'b1;
    sclk = 1'b0;
    #40;
    check_reset("mid");
    rst = 1'b0;
    #80;
    cs_n_pin = 1'b0;
    #80;
    check("rs_busy", busy, 1'b1);
    xfer(8'hC3, 8, 1'b0, 8'h00, 1'b1, got);
    check("rs_miso", got, IdleByte);
    #80;
    cs_n_pin = 1'b1;
    #160;
    check("rs_rx_n", rx_log.size(), 1);
    check("rs_rx0", rx_log[0], 8'hC3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
